// File: rtl/risc_spm_pkg.sv
// Shared RISC_SPM constants and loader state encoding.
// Used by the program loader and its checksum accumulator.
package risc_spm_pkg;

  localparam int word_size   = 8;
  localparam int memory_size = 256;

  localparam logic [word_size-1:0] CSUM_OK = 8'h00;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WR,
    S_CHK,
    S_CSUM,
    S_RUN,
    S_ERR
  } load_state_t;

  // LEN of 0 encodes a full image, so the last index wraps to 8'hFF.
  function automatic logic [word_size-1:0] last_index(
    input logic [word_size-1:0] len
  );
    return len - 8'd1;
  endfunction

endpackage

// File: rtl/load_checksum.sv
// 8-bit carry-discarding frame accumulator for the program loader.
// zero reports whether the sum including this cycle's byte is CSUM_OK.
module load_checksum
  import risc_spm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add,
  input  logic [word_size-1:0] din,
  output logic                 zero
);

  logic [word_size-1:0] sum;
  logic [word_size-1:0] base;
  logic [word_size-1:0] nxt;

  assign base = clr ? '0 : sum;
  assign nxt  = add ? base + din : base;
  assign zero = (nxt == CSUM_OK);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else begin
      sum <= nxt;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: LEN/DATA/CSUM byte stream into SRAM, then releases the CPU.
// Optional read-back verify is enabled by defining LOADER_VERIFY_EN.
module program_loader
  import risc_spm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [word_size-1:0] in_data,
  output logic                 in_ready,
  output logic [word_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_word,
  output logic                 mem_sel,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error
);

  load_state_t state;

  logic [word_size-1:0] idx;
  logic [word_size-1:0] last_idx;
  logic                 last_q;
  logic                 accept;
  logic                 is_last;
  logic                 take;
  logic                 csum_take;
  logic                 ck_clr;
  logic                 ck_zero;
  logic                 word_bad;

`ifdef LOADER_VERIFY_EN
  localparam bit verify = 1'b1;
  assign word_bad = (mem_word != mem_data);
`else
  localparam bit verify = 1'b0;
  logic unused_word;
  assign unused_word = ^mem_word;
  assign word_bad    = 1'b0;
`endif

  assign accept  = in_valid & in_ready;
  assign is_last = (idx == last_idx);
  assign ck_clr  = accept & (state == S_LEN);

  // Full-rate mode lets S_WR accept the next data byte or the CSUM byte.
  assign take = accept & (
    (state == S_DATA) |
    (!verify & (state == S_WR) & ~last_q)
  );
  assign csum_take = accept & (
    (state == S_CSUM) |
    (!verify & (state == S_WR) & last_q)
  );

  load_checksum u_ck (
    .clk  (clk),
    .rst  (rst),
    .clr  (ck_clr),
    .add  (accept),
    .din  (in_data),
    .zero (ck_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LEN;
      in_ready    <= 1'b1;
      mem_address <= '0;
      mem_data    <= '0;
      mem_write   <= 1'b0;
      mem_sel     <= 1'b1;
      cpu_rst     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      last_q      <= 1'b0;
    end else begin
      if (take) begin
        mem_address <= idx;
        mem_data    <= in_data;
        mem_write   <= 1'b1;
        last_q      <= is_last;
      end

      unique case (state)
        S_LEN: begin
          if (accept) begin
            last_idx <= last_index(in_data);
            idx      <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (take) begin
            state <= S_WR;
            if (verify) begin
              in_ready <= 1'b0;
            end else if (!is_last) begin
              idx <= idx + 8'd1;
            end
          end
        end
        S_WR: begin
          if (verify) begin
            mem_write <= 1'b0;
            state     <= S_CHK;
          end else if (csum_take) begin
            mem_write <= 1'b0;
          end else if (take) begin
            if (!is_last) begin
              idx <= idx + 8'd1;
            end
          end else begin
            mem_write <= 1'b0;
            state     <= last_q ? S_CSUM : S_DATA;
          end
        end
        S_CHK: begin
          if (word_bad) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            in_ready <= 1'b1;
            if (last_q) begin
              state <= S_CSUM;
            end else begin
              idx   <= idx + 8'd1;
              state <= S_DATA;
            end
          end
        end
        S_CSUM: begin
        end
        S_RUN: begin
        end
        S_ERR: begin
        end
        default: begin
          state    <= S_ERR;
          error    <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase

      // Frame close: the CSUM byte decides between run and error.
      if (csum_take) begin
        in_ready  <= 1'b0;
        mem_write <= 1'b0;
        if (ck_zero) begin
          state   <= S_RUN;
          mem_sel <= 1'b0;
          cpu_rst <= 1'b1;
          done    <= 1'b1;
        end else begin
          state <= S_ERR;
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected SRAM writes are queued
// at stimulus time and popped by a monitor whenever mem_write is seen.
module tb_program_loader;
  import risc_spm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_write;
  logic [7:0] mem_word;
  logic       mem_sel;
  logic       cpu_rst;
  logic       done;
  logic       error;
  logic       corrupt_en;

  logic [7:0] sram [256];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_write   (mem_write),
    .mem_word    (mem_word),
    .mem_sel     (mem_sel),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write && mem_sel) sram[mem_address] <= mem_data;
  end

  assign mem_word = sram[mem_address] ^
    ((corrupt_en && mem_address == 8'd1) ? 8'hFF : 8'h00);

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  wr_t e;
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_extra got %0h:%0h want none",
                 mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 16'(mem_address), 16'(e.a));
        check("wr_data", 16'(mem_data), 16'(e.d));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1 byte %0h", b);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_send(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({a, b});
    send(b);
  endtask

  task automatic frame(input logic [7:0] len, input logic [7:0] d[$],
                       input logic [7:0] csum, input int gapmax);
    send(len);
    foreach (d[i]) begin
      idle($urandom_range(0, gapmax));
      push_send(8'(i), d[i]);
    end
    idle($urandom_range(0, gapmax));
    send(csum);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] full[$];
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    corrupt_en = 1'b0;
    for (int i = 0; i < 256; i++) sram[i] = 8'h5A;
    idle(2);
    rst = 1'b0;

    check("rst_ready", 16'(in_ready), 16'd1);
    check("rst_addr", 16'(mem_address), 16'd0);
    check("rst_data", 16'(mem_data), 16'd0);
    check("rst_write", 16'(mem_write), 16'd0);
    check("rst_sel", 16'(mem_sel), 16'd1);
    check("rst_cpu", 16'(cpu_rst), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_err", 16'(error), 16'd0);

    // 03+51+92+00 = E6, so the good checksum is 1A.
    frame(8'd3, '{8'h51, 8'h92, 8'h00}, 8'h1A, 0);
    check("t1_done", 16'(done), 16'd1);
    check("t1_cpu", 16'(cpu_rst), 16'd1);
    check("t1_sel", 16'(mem_sel), 16'd0);
    check("t1_ready", 16'(in_ready), 16'd0);
    check("t1_err", 16'(error), 16'd0);
    check("t1_m0", 16'(sram[0]), 16'h51);
    check("t1_m1", 16'(sram[1]), 16'h92);
    check("t1_m2", 16'(sram[2]), 16'h00);
    check("t1_q", 16'(exp_q.size()), 16'd0);

    do_reset();
    check("t2_rst_cpu", 16'(cpu_rst), 16'd0);
    check("t2_rst_done", 16'(done), 16'd0);
    check("t2_rst_sel", 16'(mem_sel), 16'd1);
    frame(8'd3, '{8'h51, 8'h92, 8'h00}, 8'h1B, 0);
    check("t2_err", 16'(error), 16'd1);
    check("t2_cpu", 16'(cpu_rst), 16'd0);
    check("t2_done", 16'(done), 16'd0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    idle(4);
    check("t2_ready", 16'(in_ready), 16'd0);
    check("t2_err_hold", 16'(error), 16'd1);
    in_valid = 1'b0;
    check("t2_q", 16'(exp_q.size()), 16'd0);

    // 0+1+...+255 = 7F80, so the checksum is 80.
    do_reset();
    for (int i = 0; i < 256; i++) full.push_back(8'(i));
    frame(8'd0, full, 8'h80, 0);
    check("t3_done", 16'(done), 16'd1);
    check("t3_m255", 16'(sram[255]), 16'hFF);
    check("t3_m0", 16'(sram[0]), 16'h00);
    check("t3_m128", 16'(sram[128]), 16'h80);
    check("t3_q", 16'(exp_q.size()), 16'd0);

    // 04+A1+B2+C3+D4 = 2EE -> EE, checksum 12.
    do_reset();
    frame(8'd4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 8'h12, 3);
    check("t4_done", 16'(done), 16'd1);
    check("t4_m3", 16'(sram[3]), 16'hD4);
    check("t4_m4", 16'(sram[4]), 16'h04);
    check("t4_q", 16'(exp_q.size()), 16'd0);

    do_reset();
    send(8'd5);
    push_send(8'd0, 8'h11);
    push_send(8'd1, 8'h22);
    idle(1);
    do_reset();
    check("t5_cpu", 16'(cpu_rst), 16'd0);
    check("t5_ready", 16'(in_ready), 16'd1);
    check("t5_done", 16'(done), 16'd0);
    // 01+77 = 78, checksum 88.
    frame(8'd1, '{8'h77}, 8'h88, 0);
    check("t5_fin", 16'(done), 16'd1);
    check("t5_m0", 16'(sram[0]), 16'h77);
    check("t5_m1", 16'(sram[1]), 16'h22);
    check("t5_q", 16'(exp_q.size()), 16'd0);

`ifdef LOADER_VERIFY_EN
    do_reset();
    corrupt_en = 1'b1;
    send(8'd3);
    push_send(8'd0, 8'h51);
    push_send(8'd1, 8'h92);
    idle(4);
    check("t6_err", 16'(error), 16'd1);
    check("t6_done", 16'(done), 16'd0);
    check("t6_cpu", 16'(cpu_rst), 16'd0);
    check("t6_ready", 16'(in_ready), 16'd0);
    check("t6_q", 16'(exp_q.size()), 16'd0);
    corrupt_en = 1'b0;
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
